neuron_sequencer: RTL and testbench
===================================

// Module: neuron_sequencer
// PURPOSE
//  Sequences the shared, free-running fp pipeline (int->fp convert, then fp multiply) for one neuron.
//  On iSTART, walks indices 0..N_INPUTS-1, issuing one synchronous input/weight RAM read per cycle.
//  The RAM outputs feed the neuron datapath directly.
//  Tracks in-flight items with a valid shift register and generates the result-buffer write strobe/address.
//  The datapath has no enable and cannot stall, so the sequencer alone defines valid timing.
// PARAMETERS
//  N_INPUTS  2   products per run; legal 1..256
//  RD_LAT    1   read latency of input/weight RAMs, cycles; legal 0..4
//  PIPE_LAT  11  iDATA/iWEIGHT -> oDATA latency of convert+multiply, cycles; legal 1..32
//  IDX_W     max(1,$clog2(N_INPUTS))  local, index width
// PORTS
//  iCLK       in   1      single clock, all state on rising edge
//  iRST       in   1      synchronous reset, active-high
//  iSTART     in   1      run request; sampled only in IDLE
//  oBUSY      out  1      1 whenever state != IDLE
//  oDONE      out  1      one-cycle pulse: all N_INPUTS products written
//  oRD_EN     out  1      read strobe to input RAM and weight RAM
//  oRD_ADDR   out  IDX_W  index read this cycle (shared by both RAMs)
//  oWR_EN     out  1      product on the neuron's oDATA valid this cycle; write it
//  oWR_ADDR   out  IDX_W  result-buffer index for oWR_EN
// BEHAVIOUR
//  Reset (iRST=1 at an edge): state=IDLE; oBUSY=0, oDONE=0, oRD_EN=0, oRD_ADDR=0, oWR_EN=0, oWR_ADDR=0.
//   Reset also clears the valid/index delay line.
//   Reset mid-run aborts: products already in the datapath are never written (oWR_EN suppressed).
//  Delay line: depth D = RD_LAT + PIPE_LAT; carries {valid, index}.
//   Entry k pushed in the cycle oRD_EN=1 with oRD_ADDR=k.
//   Emerges as oWR_EN=1, oWR_ADDR=k exactly D cycles later.
//   oWR_* are registered outputs of the delay-line tail.
//  FSM:
//   IDLE : iSTART=1 -> ISSUE with idx=0; else stay.
//   ISSUE: oRD_EN=1, oRD_ADDR=idx every cycle, no bubbles.
//          If idx==N_INPUTS-1 -> DRAIN; else idx++.
//   DRAIN: oRD_EN=0; wait until the delay line holds no valid entry and oWR_EN=0 -> DONE.
//   DONE : oDONE=1 for exactly this cycle -> IDLE.
//  Timing (iSTART high at edge s):
//   oRD_EN high cycles s+1..s+N_INPUTS.
//   oWR_EN high cycles s+1+D..s+N_INPUTS+D.
//   oDONE at s+N_INPUTS+D+1.
//   oBUSY high s+1..s+N_INPUTS+D+1.
//  iSTART outside IDLE (including in DONE) is ignored, not queued.
//   Next run accepted at the earliest the cycle after oDONE.
//  N_INPUTS=1: ISSUE lasts one cycle. idx never exceeds N_INPUTS-1; no wrap.
//  Exactly N_INPUTS oWR_EN pulses per completed run, addresses strictly 0,1,..,N_INPUTS-1 in order.
//  oRD_EN and oWR_EN may be high in the same cycle (overlap when N_INPUTS > D); both honoured.
//  iRST coincident with iSTART: reset wins; stay IDLE.
// TESTING (N_INPUTS=2, RD_LAT=1, PIPE_LAT=11 so D=12, unless noted)
//  1 iRST 3 cycles, then idle 5 cycles -> all outputs 0, oBUSY=0.
//  2 iSTART pulse at cycle 0:
//     -> oRD_EN cycles 1,2, addr 0,1;
//     -> oWR_EN cycles 13,14, addr 0,1;
//     -> oDONE only at 15; oBUSY 1..15.
//  3 iSTART held high continuously:
//     -> runs back-to-back; second run's first oRD_EN at cycle 17;
//     -> oDONE at 15 and 31; iSTART during busy has no effect.
//  4 iRST at cycle 5 of a run -> oWR_EN never asserts, oDONE never asserts, IDLE at cycle 6.
//     iSTART at 10 -> oDONE at 25.
//  5 N_INPUTS=16, PIPE_LAT=3 (D=4):
//     -> oRD_EN cycles 1..16 overlap oWR_EN cycles 5..20, addr 0..15 in order;
//     -> oDONE at 21.
//  6 Model check with real RAMs + neuron: inputs {0,1}, weights {2.0,-1.5}
//     -> buffer {0x00000000, 0xBFC00000}.

Source files
------------

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: walks the input/weight RAMs for one neuron, tracks the
// items travelling through the fixed-latency convert+multiply pipeline and
// produces the result-buffer write strobe/address at the pipeline output.
//
// Handshake: there is no back-pressure anywhere. A read issued in a cycle
// (oRD_EN=1, oRD_ADDR=k) produces a product whose write (oWR_EN=1,
// oWR_ADDR=k) appears exactly RD_LAT+PIPE_LAT cycles later; iSTART is only a
// request and is looked at only while the sequencer is idle.
module neuron_sequencer #(
  parameter int N_INPUTS = 2,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 11,
  localparam int IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oRD_EN,
  output logic [IDX_W-1:0] oRD_ADDR,
  output logic             oWR_EN,
  output logic [IDX_W-1:0] oWR_ADDR,
  output logic [1:0]       oDBG_STATE
);

  // Total read-to-write latency: RAM read plus convert+multiply.
  localparam int D = RD_LAT + PIPE_LAT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Delay line {valid, index}; the last stage drives oWR_EN/oWR_ADDR.
  logic [D-1:0]     vld_q, vld_d;
  logic [IDX_W-1:0] adr_q [D];
  logic [IDX_W-1:0] adr_d [D];

  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic             pending;

  // Any valid item still upstream of the tail stage. When this is clear in
  // DRAIN, the tail write (if any) is happening now and the line will be
  // empty next cycle, so DONE can follow immediately.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < D - 1; i++) begin
      pending = pending | vld_q[i];
    end
  end

  // FSM next-state and read-side outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        rd_en   = 1'b1;
        rd_addr = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Delay-line shift: head takes this cycle's read, others move one stage on.
  always_comb begin
    vld_d[0] = rd_en;
    adr_d[0] = rd_addr;
    for (int i = 1; i < D; i++) begin
      vld_d[i] = vld_q[i-1];
      adr_d[i] = adr_q[i-1];
    end
  end

  // State, index and delay-line registers; reset also drops in-flight items.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < D; i++) begin
        adr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      for (int i = 0; i < D; i++) begin
        adr_q[i] <= adr_d[i];
      end
    end
  end

  assign oBUSY      = (state_q != S_IDLE);
  assign oDONE      = (state_q == S_DONE);
  assign oRD_EN     = rd_en;
  assign oRD_ADDR   = rd_addr;
  assign oWR_EN     = vld_q[D-1];
  assign oWR_ADDR   = adr_q[D-1];
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Bench for neuron_sequencer: two instances (N=2/D=12 and N=16/D=4) driven
// by directed then random start/reset traffic. A run model pushes expected
// read/write/done events into queues; a monitor pops and compares them as
// the DUTs produce outputs.
module tb_neuron_sequencer;

  localparam int NA = 2;
  localparam int DA = 12;
  localparam int NB = 16;
  localparam int DB = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] addr;
  } ev_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_busy, a_done, a_rd_en, a_wr_en;
  logic [0:0] a_rd_addr, a_wr_addr;
  logic [1:0] a_state;
  logic       b_busy, b_done, b_rd_en, b_wr_en;
  logic [3:0] b_rd_addr, b_wr_addr;
  logic [1:0] b_state;

  neuron_sequencer #(.N_INPUTS(NA), .RD_LAT(1), .PIPE_LAT(11)) dut_a (
    .iCLK(clk), .iRST(rst), .iSTART(start_a),
    .oBUSY(a_busy), .oDONE(a_done), .oRD_EN(a_rd_en), .oRD_ADDR(a_rd_addr),
    .oWR_EN(a_wr_en), .oWR_ADDR(a_wr_addr), .oDBG_STATE(a_state)
  );

  neuron_sequencer #(.N_INPUTS(NB), .RD_LAT(1), .PIPE_LAT(3)) dut_b (
    .iCLK(clk), .iRST(rst), .iSTART(start_b),
    .oBUSY(b_busy), .oDONE(b_done), .oRD_EN(b_rd_en), .oRD_ADDR(b_rd_addr),
    .oWR_EN(b_wr_en), .oWR_ADDR(b_wr_addr), .oDBG_STATE(b_state)
  );

  // scoreboard state
  ev_t a_rd_q[$], a_wr_q[$], a_dn_q[$];
  ev_t b_rd_q[$], b_wr_q[$], b_dn_q[$];
  int  a_free = 0, a_bs = 1, a_be = 0;
  int  b_free = 0, b_bs = 1, b_be = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  bit  zero_win = 1'b0;
  bit  fin_req = 1'b0;

  // reference model: a run accepted in cycle s reads index k in cycle s+1+k,
  // writes it D cycles later, and completes one cycle after the last write
  task automatic push_run(input bit sel, input int s);
    int n, d;
    n = sel ? NB : NA;
    d = sel ? DB : DA;
    for (int k = 0; k < n; k++) begin
      if (sel) begin
        b_rd_q.push_back('{cyc: 32'(s + 1 + k), addr: 16'(k)});
        b_wr_q.push_back('{cyc: 32'(s + 1 + d + k), addr: 16'(k)});
      end else begin
        a_rd_q.push_back('{cyc: 32'(s + 1 + k), addr: 16'(k)});
        a_wr_q.push_back('{cyc: 32'(s + 1 + d + k), addr: 16'(k)});
      end
    end
    if (sel) begin
      b_dn_q.push_back('{cyc: 32'(s + n + d + 1), addr: 16'd0});
      b_bs = s + 1; b_be = s + n + d + 1; b_free = s + n + d + 2;
    end else begin
      a_dn_q.push_back('{cyc: 32'(s + n + d + 1), addr: 16'd0});
      a_bs = s + 1; a_be = s + n + d + 1; a_free = s + n + d + 2;
    end
  endtask

  // reset at the end of cycle r cancels every event scheduled after r
  task automatic flush(input int r);
    while (a_rd_q.size() > 0 && int'(a_rd_q[$].cyc) > r) void'(a_rd_q.pop_back());
    while (a_wr_q.size() > 0 && int'(a_wr_q[$].cyc) > r) void'(a_wr_q.pop_back());
    while (a_dn_q.size() > 0 && int'(a_dn_q[$].cyc) > r) void'(a_dn_q.pop_back());
    while (b_rd_q.size() > 0 && int'(b_rd_q[$].cyc) > r) void'(b_rd_q.pop_back());
    while (b_wr_q.size() > 0 && int'(b_wr_q[$].cyc) > r) void'(b_wr_q.pop_back());
    while (b_dn_q.size() > 0 && int'(b_dn_q[$].cyc) > r) void'(b_dn_q.pop_back());
    if (a_be > r) a_be = r;
    if (b_be > r) b_be = r;
    a_free = r + 1;
    b_free = r + 1;
  endtask

  // driver: one call = one cycle of inputs, model updated for that cycle
  task automatic step(input bit sa, input bit sb, input bit r);
    @(posedge clk);
    #1;
    start_a = sa;
    start_b = sb;
    rst     = r;
    if (r) begin
      flush(cyc);
    end else begin
      if (sa && cyc >= a_free) push_run(1'b0, cyc);
      if (sb && cyc >= b_free) push_run(1'b1, cyc);
    end
  endtask

  // monitor helpers (called only from the monitor process)
  task automatic evt(input string nm, input logic en, input int addr,
                     input int qn, input ev_t f, output bit pop);
    pop = 1'b0;
    if (qn > 0 && int'(f.cyc) < cyc) begin
      checks++; errors++; pop = 1'b1;
      $display("FAIL %s missed: expected at cycle %0d addr %0d, now cycle %0d",
               nm, f.cyc, f.addr, cyc);
    end else if (en === 1'b1) begin
      checks++;
      if (qn > 0 && int'(f.cyc) == cyc) begin
        pop = 1'b1;
        if (addr != int'(f.addr)) begin
          errors++;
          $display("FAIL %s addr cycle %0d: got %0d expected %0d", nm, cyc, addr, f.addr);
        end
      end else begin
        errors++;
        $display("FAIL %s unexpected at cycle %0d addr %0d (expected none)", nm, cyc, addr);
      end
    end else if (en !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s strobe unknown at cycle %0d: got %b expected 0/1", nm, cyc, en);
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    ev_t f;
    bit  p;
    if (mon_en) begin
      f = (a_rd_q.size() > 0) ? a_rd_q[0] : '0;
      evt("a_rd", a_rd_en, int'(a_rd_addr), a_rd_q.size(), f, p);
      if (p) void'(a_rd_q.pop_front());
      f = (a_wr_q.size() > 0) ? a_wr_q[0] : '0;
      evt("a_wr", a_wr_en, int'(a_wr_addr), a_wr_q.size(), f, p);
      if (p) void'(a_wr_q.pop_front());
      f = (a_dn_q.size() > 0) ? a_dn_q[0] : '0;
      evt("a_done", a_done, 0, a_dn_q.size(), f, p);
      if (p) void'(a_dn_q.pop_front());
      f = (b_rd_q.size() > 0) ? b_rd_q[0] : '0;
      evt("b_rd", b_rd_en, int'(b_rd_addr), b_rd_q.size(), f, p);
      if (p) void'(b_rd_q.pop_front());
      f = (b_wr_q.size() > 0) ? b_wr_q[0] : '0;
      evt("b_wr", b_wr_en, int'(b_wr_addr), b_wr_q.size(), f, p);
      if (p) void'(b_wr_q.pop_front());
      f = (b_dn_q.size() > 0) ? b_dn_q[0] : '0;
      evt("b_done", b_done, 0, b_dn_q.size(), f, p);
      if (p) void'(b_dn_q.pop_front());
      chk("a_busy", int'(a_busy), int'(cyc >= a_bs && cyc <= a_be));
      chk("b_busy", int'(b_busy), int'(cyc >= b_bs && cyc <= b_be));
      if (zero_win) begin
        chk("a_idle_rd_addr", int'(a_rd_addr), 0);
        chk("a_idle_wr_addr", int'(a_wr_addr), 0);
        chk("a_idle_wr_en", int'(a_wr_en), 0);
        chk("b_idle_rd_addr", int'(b_rd_addr), 0);
        chk("b_idle_wr_addr", int'(b_wr_addr), 0);
        chk("b_idle_done", int'(b_done), 0);
      end
      if (fin_req) begin
        chk("a_rd_left", a_rd_q.size(), 0);
        chk("a_wr_left", a_wr_q.size(), 0);
        chk("a_done_left", a_dn_q.size(), 0);
        chk("b_rd_left", b_rd_q.size(), 0);
        chk("b_wr_left", b_wr_q.size(), 0);
        chk("b_done_left", b_dn_q.size(), 0);
      end
    end
  end

  // stimulus
  initial begin
    // reset held for three cycles, then five idle cycles with outputs at 0
    step(0, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 1);
    step(0, 0, 1);
    zero_win = 1'b1;
    repeat (5) step(0, 0, 0);
    zero_win = 1'b0;

    // single start pulse
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);

    // start held high: back-to-back runs, extra requests ignored
    repeat (40) step(1, 0, 0);
    repeat (20) step(0, 0, 0);

    // reset five cycles into a run, then a fresh run ten cycles after start
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);

    // reset coincident with start: stays idle
    step(1, 1, 1);
    repeat (3) step(0, 0, 0);

    // long run overlapping reads and writes on the N=16 instance
    step(0, 1, 0);
    repeat (25) step(0, 0, 0);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 79) == 0);
    end

    // drain and confirm nothing expected is left over
    repeat (40) step(0, 0, 0);
    fin_req = 1'b1;
    step(0, 0, 0);
    fin_req = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
